// File: rtl/parametric_stream_mux.sv
// Registered N:1 stream multiplexer with valid/ready handshakes, fixed-select or
// round-robin channel choice, and per-packet channel locking.
module parametric_stream_mux #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MODE_IN,
    input  logic [SEL_WIDTH-1:0]  SEL_IN,
    input  logic [DATA_WIDTH-1:0] IN_DATA [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] IN_LAST,
    input  logic [NUM_INPUTS-1:0] IN_VALID,
    output logic [NUM_INPUTS-1:0] IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_LAST,
    output logic [SEL_WIDTH-1:0]  OUT_SRC,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
);

    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    localparam logic [SEL_WIDTH-1:0] RR_RESET  = SEL_WIDTH'(NUM_INPUTS - 1);
    localparam logic [SEL_WIDTH:0]   NUM_WIDE  = (SEL_WIDTH + 1)'(NUM_INPUTS);

    lock_state_t             state_r;
    lock_state_t             state_nxt_s;
    logic [SEL_WIDTH-1:0]    lock_ch_r;
    logic [SEL_WIDTH-1:0]    lock_ch_nxt_s;
    logic [SEL_WIDTH-1:0]    rr_ptr_r;
    logic [SEL_WIDTH-1:0]    rr_ptr_nxt_s;

    logic                    load_en_s;
    logic                    rr_found_s;
    logic [SEL_WIDTH-1:0]    rr_idx_s;
    logic [SEL_WIDTH:0]      rr_cand_s;
    logic                    grant_vld_s;
    logic [SEL_WIDTH-1:0]    grant_idx_s;
    logic                    accept_s;
    logic                    acc_last_s;
    logic [DATA_WIDTH-1:0]   acc_data_s;

    // The output register can take a new beat when empty or being drained this cycle.
    assign load_en_s = !OUT_VALID || OUT_READY;

    // Round-robin search: first valid channel after the pointer, wrapping around.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = '0;
        rr_cand_s  = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            rr_cand_s = {1'b0, rr_ptr_r} + (SEL_WIDTH + 1)'(k);
            if (rr_cand_s >= NUM_WIDE) begin
                rr_cand_s = rr_cand_s - NUM_WIDE;
            end else begin
                rr_cand_s = rr_cand_s;
            end
            if (!rr_found_s && IN_VALID[rr_cand_s[SEL_WIDTH-1:0]]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = rr_cand_s[SEL_WIDTH-1:0];
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Grant selection: a held lock beats both selection modes.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        if (state_r == ST_LOCKED) begin
            grant_vld_s = 1'b1;
            grant_idx_s = lock_ch_r;
        end else if (!MODE_IN) begin
            if ({1'b0, SEL_IN} < NUM_WIDE) begin
                grant_vld_s = 1'b1;
                grant_idx_s = SEL_IN;
            end else begin
                grant_vld_s = 1'b0;
                grant_idx_s = '0;
            end
        end else begin
            grant_vld_s = rr_found_s;
            grant_idx_s = rr_idx_s;
        end
    end

    // Ready fan-out and capture of the granted channel's beat.
    always_comb begin
        IN_READY   = '0;
        accept_s   = 1'b0;
        acc_last_s = 1'b0;
        acc_data_s = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (load_en_s && grant_vld_s && (grant_idx_s == SEL_WIDTH'(i))) begin
                IN_READY[i] = 1'b1;
                accept_s    = IN_VALID[i];
                acc_last_s  = IN_LAST[i];
                acc_data_s  = IN_DATA[i];
            end else begin
                IN_READY[i] = 1'b0;
            end
        end
    end

    // Lock FSM next state; the RR pointer only advances when a packet completes.
    always_comb begin
        state_nxt_s   = state_r;
        lock_ch_nxt_s = lock_ch_r;
        rr_ptr_nxt_s  = rr_ptr_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (accept_s && !acc_last_s) begin
                    state_nxt_s   = ST_LOCKED;
                    lock_ch_nxt_s = grant_idx_s;
                end else if (accept_s) begin
                    rr_ptr_nxt_s  = grant_idx_s;
                end else begin
                    state_nxt_s   = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept_s && acc_last_s) begin
                    state_nxt_s   = ST_UNLOCKED;
                    rr_ptr_nxt_s  = grant_idx_s;
                end else begin
                    state_nxt_s   = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_UNLOCKED;
            end
        endcase
    end

    // Lock and arbitration state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_UNLOCKED;
            lock_ch_r <= '0;
            rr_ptr_r  <= RR_RESET;
        end else begin
            state_r   <= state_nxt_s;
            lock_ch_r <= lock_ch_nxt_s;
            rr_ptr_r  <= rr_ptr_nxt_s;
        end
    end

    // Output stage: payload holds when nothing new is loaded.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_LAST  <= 1'b0;
            OUT_SRC   <= '0;
        end else if (accept_s) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= acc_data_s;
            OUT_LAST  <= acc_last_s;
            OUT_SRC   <= grant_idx_s;
        end else if (load_en_s) begin
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= OUT_VALID;
        end
    end

endmodule

// File: tb/tb_parametric_stream_mux.sv
// Vector-table bench for parametric_stream_mux with a beat scoreboard, plus a
// three-input instance for the out-of-range select case.
module tb_parametric_stream_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] in_data [4];
    logic [3:0] in_last, in_valid, in_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [1:0] out_src;
    logic       out_valid, out_ready;

    logic       mode3;
    logic [1:0] sel3;
    logic [7:0] data3 [3];
    logic [2:0] last3, valid3, ready3;
    logic [7:0] od3;
    logic       ol3;
    logic [1:0] os3;
    logic       ov3, or3;

    parametric_stream_mux #(.DATA_WIDTH(8), .NUM_INPUTS(4)) dut (
        .CLK(clk), .RST(rst), .MODE_IN(mode), .SEL_IN(sel),
        .IN_DATA(in_data), .IN_LAST(in_last), .IN_VALID(in_valid), .IN_READY(in_ready),
        .OUT_DATA(out_data), .OUT_LAST(out_last), .OUT_SRC(out_src),
        .OUT_VALID(out_valid), .OUT_READY(out_ready)
    );

    parametric_stream_mux #(.DATA_WIDTH(8), .NUM_INPUTS(3)) dut3 (
        .CLK(clk), .RST(rst), .MODE_IN(mode3), .SEL_IN(sel3),
        .IN_DATA(data3), .IN_LAST(last3), .IN_VALID(valid3), .IN_READY(ready3),
        .OUT_DATA(od3), .OUT_LAST(ol3), .OUT_SRC(os3),
        .OUT_VALID(ov3), .OUT_READY(or3)
    );

    typedef struct {
        logic        rst;
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] src;
    } beat_t;

    vec_t  vecs[$];
    beat_t sb[$];
    int    tests = 0;
    int    fails = 0;

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] v, input logic [3:0] l,
                                input logic [31:0] d, input logic o,
                                input logic [3:0] er, input logic eo);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.valid = v; t.last = l;
        t.data = d; t.ordy = o; t.exp_rdy = er; t.exp_ov = eo;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        vec_t  v;
        beat_t b;
        logic  prev_ov;
        int    g;

        // rst mode sel valid last data{ch3,ch2,ch1,ch0} out_ready exp_ready exp_ov
        // Fixed select, two-beat packet on ch2
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000, 32'h00A1_0000, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 4'b0100, 4'b0100, 32'h00A2_0000, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0100, 1'b0));
        // Lock on ch1 while SEL_IN moves to 3
        vecs.push_back(mk(1'b0, 1'b0, 2'd1, 4'b0010, 4'b0000, 32'h0000_B100, 1'b1, 4'b0010, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 4'b1010, 4'b1000, 32'hC100_B200, 1'b1, 4'b0010, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 4'b1010, 4'b1010, 32'hC100_B300, 1'b1, 4'b0010, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 4'b1000, 4'b1000, 32'hC100_0000, 1'b1, 4'b1000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b1000, 1'b0));
        // Round-robin, all channels valid with single-beat packets
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h4030_2010, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h4030_2010, 1'b1, 4'b0010, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h4030_2010, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h4030_2010, 1'b1, 4'b1000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h4030_2010, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0));
        // Backpressure for three cycles
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100, 32'h00D1_0000, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100, 32'h00D2_0000, 1'b0, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100, 32'h00D2_0000, 1'b0, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100, 32'h00D2_0000, 1'b0, 4'b0000, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0100, 4'b0100, 32'h00D2_0000, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0));
        // Reset mid-packet on ch0, lock must be gone afterwards
        vecs.push_back(mk(1'b0, 1'b0, 2'd0, 4'b0001, 4'b0000, 32'h0000_00E1, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000, 32'h0000_00E2, 1'b0, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 2'd2, 4'b0101, 4'b0100, 32'h00E3_00E4, 1'b1, 4'b0100, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b1111, 4'b1111, 32'h5453_5251, 1'b1, 4'b0001, 1'b1));
        vecs.push_back(mk(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0));

        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_last = 4'b0; out_ready = 1'b1;
        foreach (in_data[c]) in_data[c] = 8'h00;
        mode3 = 1'b0; sel3 = 2'd0; valid3 = 3'b0; last3 = 3'b0; or3 = 1'b1;
        foreach (data3[c]) data3[c] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_last", 32'(out_last), 32'd0);
        chk("reset out_src", 32'(out_src), 32'd0);
        chk("reset n3 out_valid", 32'(ov3), 32'd0);

        prev_ov = 1'b0;
        foreach (vecs[i]) begin
            v = vecs[i];
            rst = v.rst; mode = v.mode; sel = v.sel;
            in_valid = v.valid; in_last = v.last; out_ready = v.ordy;
            for (int c = 0; c < 4; c++) in_data[c] = v.data[c*8 +: 8];
            #1;
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(v.exp_rdy));
            if (!v.rst && v.ordy && prev_ov && sb.size() > 0) b = sb.pop_front();
            if (!v.rst && (v.valid & v.exp_rdy) != 4'b0) begin
                g = 0;
                for (int c = 0; c < 4; c++) if (v.valid[c] && v.exp_rdy[c]) g = c;
                b.data = v.data[g*8 +: 8];
                b.last = v.last[g];
                b.src  = 2'(g);
                sb.push_back(b);
            end
            if (v.rst) sb.delete();
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(v.exp_ov));
            if (v.rst) begin
                chk($sformatf("v%0d rst out_data", i), 32'(out_data), 32'd0);
                chk($sformatf("v%0d rst out_src", i), 32'(out_src), 32'd0);
                chk($sformatf("v%0d rst out_last", i), 32'(out_last), 32'd0);
            end else if (v.exp_ov) begin
                if (sb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL v%0d scoreboard: got empty queue, expected a pending beat", i);
                end else begin
                    chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(sb[0].data));
                    chk($sformatf("v%0d out_last", i), 32'(out_last), 32'(sb[0].last));
                    chk($sformatf("v%0d out_src", i), 32'(out_src), 32'(sb[0].src));
                end
            end
            prev_ov = v.exp_ov;
            @(negedge clk);
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        // Three-input instance: select index 3 is out of range
        rst = 1'b0; mode3 = 1'b0; sel3 = 2'd3; valid3 = 3'b111; last3 = 3'b111;
        data3[0] = 8'h11; data3[1] = 8'h22; data3[2] = 8'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("n3 sel3 in_ready c%0d", k), 32'(ready3), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("n3 sel3 out_valid c%0d", k), 32'(ov3), 32'd0);
            @(negedge clk);
        end
        sel3 = 2'd2;
        #1;
        chk("n3 sel2 in_ready", 32'(ready3), 32'b100);
        @(posedge clk);
        #1;
        chk("n3 sel2 out_valid", 32'(ov3), 32'd1);
        chk("n3 sel2 out_data", 32'(od3), 32'h77);
        chk("n3 sel2 out_src", 32'(os3), 32'd2);
        chk("n3 sel2 out_last", 32'(ol3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parametric_stream_mux.md
Name: parametric_stream_mux

Overview:
- Registered N:1 stream multiplexer with valid/ready handshakes and packet locking.
- Next generation of the combinational parametric mux. Adds two selection modes: fixed select, and round-robin arbitration across requesting channels.
- Once a packet starts on a channel, the block holds that channel until the packet's last beat.
- Sits between multiple stream producers and a single shared stream consumer.

Parameters:
- DATA_WIDTH, 8, width of each data beat.
- NUM_INPUTS, 4, number of input channels, >= 2.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the select and source-index fields (derived; do not override).

Ports:
- CLK  input  1  clock; all logic rising-edge.
- RST  input  1  reset; synchronous, active-high.
- MODE_IN  input  1  0 = fixed select via SEL_IN; 1 = round-robin arbitration.
- SEL_IN  input  SEL_WIDTH  channel index used when MODE_IN=0.
- IN_DATA  input  DATA_WIDTH x NUM_INPUTS (unpacked array)  per-channel data.
- IN_LAST  input  NUM_INPUTS  per-channel end-of-packet flag.
- IN_VALID  input  NUM_INPUTS  per-channel valid.
- IN_READY  output  NUM_INPUTS  per-channel ready (combinational).
- OUT_DATA  output  DATA_WIDTH  registered output data.
- OUT_LAST  output  1  registered end-of-packet flag.
- OUT_SRC  output  SEL_WIDTH  index of the channel that supplied the current OUT beat.
- OUT_VALID  output  1  registered output valid.
- OUT_READY  input  1  downstream ready.

Behaviour:
- Reset state, while RST=1 at a rising edge:
  - OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, OUT_SRC=0.
  - Lock cleared.
  - Round-robin pointer = NUM_INPUTS-1, so the first RR grant goes to channel 0.
  - RST overrides any handshake in the same cycle. Mid-packet reset drops the lock and any held beat.
- Load enable: load_en = !OUT_VALID || OUT_READY. Single-stage output register, full throughput, no bubbles.
- Grant (combinational), one-hot or none:
  - Locked: grant = locked channel, regardless of MODE_IN/SEL_IN.
  - Unlocked, MODE_IN=0: grant = SEL_IN if SEL_IN < NUM_INPUTS, else no grant (all IN_READY=0).
  - Unlocked, MODE_IN=1: grant = first channel with IN_VALID=1, scanning from pointer+1 upward with wrap; none if no valid.
- IN_READY[i] = load_en && grant==i. IN_READY is independent of IN_VALID[i]. In fixed mode the selected channel sees ready even when idle.
- Accept: when IN_VALID[g] && IN_READY[g], on the next edge:
  - OUT_DATA<=IN_DATA[g], OUT_LAST<=IN_LAST[g], OUT_SRC<=g, OUT_VALID<=1.
  - Latency is exactly 1 cycle from accept to OUT_VALID.
- When load_en=1 with no accept, OUT_VALID<=0. OUT_DATA, OUT_LAST and OUT_SRC hold their last values.
- When OUT_VALID && !OUT_READY, all OUT_* signals hold stable and all IN_READY=0.
- Lock FSM, states UNLOCKED and LOCKED(ch):
  - UNLOCKED to LOCKED(g): on accept with IN_LAST[g]=0.
  - LOCKED to UNLOCKED: on accept with IN_LAST=1.
  - An accept with IN_LAST=1 while UNLOCKED (single-beat packet) stays UNLOCKED.
- RR pointer update: the pointer moves to g only on an accept with IN_LAST=1, i.e. at packet end. Fairness is per packet, not per beat.
- Changes to MODE_IN or SEL_IN while LOCKED take effect after the packet ends.

Test Plan:
- Fixed mode, SEL_IN=2, OUT_READY=1, ch2 sends beats 0xA1, 0xA2 (LAST on 0xA2) -> OUT_DATA 0xA1 then 0xA2 on the consecutive cycles after each accept; OUT_SRC=2; OUT_LAST=1 only on 0xA2; IN_READY=4'b0100.
- Lock: fixed mode, ch1 sends a 3-beat packet; SEL_IN switches to 3 after beat 1 -> beats 2 and 3 still come from ch1; ch3 is granted only after ch1's LAST accept.
- Round-robin: all four channels valid with single-beat packets 0x10, 0x20, 0x30, 0x40 -> OUT_SRC sequence 0, 1, 2, 3, 0 with no bubble cycles.
- Backpressure: OUT_READY held 0 for 3 cycles with OUT_VALID=1 -> OUT_DATA, OUT_LAST and OUT_SRC are stable and IN_READY=0; a beat is accepted on the cycle OUT_READY returns to 1.
- Invalid select: NUM_INPUTS=3, SEL_IN=3, all valid -> IN_READY=0 and OUT_VALID stays 0.
- Reset mid-packet: ch0 locked after 1 of 4 beats, RST pulsed -> OUT_VALID=0 and OUT_SRC=0 next cycle; lock cleared; in RR mode ch0 is granted first.
